// File: rtl/systolic_host_dma_pkg.sv
// Shared types and defaults for the systolic host DMA.
// Load-section sequencing helper lives here so the FSM stays small.
`ifndef SYSTOLIC_INPUT_WIDTH
`define SYSTOLIC_INPUT_WIDTH 16
`endif
`ifndef SYSTOLIC_RESULT_WIDTH
`define SYSTOLIC_RESULT_WIDTH 32
`endif
`ifndef SYSTOLIC_ADDR_WIDTH
`define SYSTOLIC_ADDR_WIDTH 8
`endif
package systolic_host_dma_pkg;
  localparam int DEF_INPUT_WIDTH  = `SYSTOLIC_INPUT_WIDTH;
  localparam int DEF_RESULT_WIDTH = `SYSTOLIC_RESULT_WIDTH;
  localparam int DEF_ADDR_WIDTH   = `SYSTOLIC_ADDR_WIDTH;
`ifdef SYSTOLIC_DMA_TIMEOUT_EN
  localparam int DEF_TIMEOUT = 1024;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_I, S_LOAD_A, S_LOAD_B,
    S_START, S_WAIT, S_DRAIN, S_FIN
  } dma_state_e;

  // next non-empty load section after cur, else START
  function automatic dma_state_e next_load(
    input dma_state_e cur,
    input logic nz_i, input logic nz_a, input logic nz_b
  );
    dma_state_e nxt;
    nxt = S_START;
    if (cur == S_IDLE && nz_i)
      nxt = S_LOAD_I;
    else if ((cur == S_IDLE || cur == S_LOAD_I) && nz_a)
      nxt = S_LOAD_A;
    else if (cur != S_LOAD_B && nz_b)
      nxt = S_LOAD_B;
    return nxt;
  endfunction
endpackage

// File: rtl/systolic_host_dma_if.sv
// Host-side bundle between the DMA and its environment.
// master = DMA, slave = stream fabric / systolic_top side.
interface systolic_host_dma_if #(
  parameter int INPUT_WIDTH  = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int ADDR_WIDTH   = 8
);
  localparam int LW = ADDR_WIDTH + 1;
  logic                    go;
  logic [LW-1:0]           len_i, len_a, len_b, len_o;
  logic                    busy, done, err;
  logic                    s_valid, s_ready;
  logic [INPUT_WIDTH-1:0]  s_data;
  logic [ADDR_WIDTH-1:0]   addrI, addrA, addrB, addrO;
  logic                    enI, enA, enB;
  logic [INPUT_WIDTH-1:0]  dataI, dataA, dataB;
  logic [RESULT_WIDTH-1:0] dataO;
  logic                    ap_start, ap_done;
  logic                    m_valid, m_ready, m_last;
  logic [RESULT_WIDTH-1:0] m_data;

  modport master (
    input  go, len_i, len_a, len_b, len_o,
    input  s_valid, s_data, dataO, ap_done, m_ready,
    output busy, done, err, s_ready,
    output addrI, enI, dataI, addrA, enA, dataA,
    output addrB, enB, dataB, addrO, ap_start,
    output m_valid, m_data, m_last
  );
  modport slave (
    output go, len_i, len_a, len_b, len_o,
    output s_valid, s_data, dataO, ap_done, m_ready,
    input  busy, done, err, s_ready,
    input  addrI, enI, dataI, addrA, enA, dataA,
    input  addrB, enB, dataB, addrO, ap_start,
    input  m_valid, m_data, m_last
  );
endinterface

// File: rtl/systolic_host_dma_skid_fifo.sv
// Two-entry (data,last) skid FIFO for result words.
// Caller never pushes when full; pop only with valid.
module systolic_host_dma_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;

  // storage, ring pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (i_pop)
        r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_valid = (r_cnt != 2'd0);
  assign o_count = r_cnt;
endmodule

// File: rtl/systolic_host_dma.sv
// Host DMA: stream -> I/A/B memories, ap_start/ap_done, result drain.
// Optional WAIT watchdog under SYSTOLIC_DMA_TIMEOUT_EN.
module systolic_host_dma
  import systolic_host_dma_pkg::*;
#(
`ifdef SYSTOLIC_DMA_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
`endif
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input logic clk,
  input logic rst,
  systolic_host_dma_if.master bus
);
  localparam int LW = ADDR_WIDTH + 1;

  dma_state_e              r_state;
  logic [LW-1:0]           r_len_i, r_len_a, r_len_b, r_len_o;
  logic [LW-1:0]           r_cnt, r_icnt;
  logic                    r_busy, r_done, r_s_ready, r_ap_start;
  logic                    r_enI, r_enA, r_enB;
  logic                    r_infl, r_infl_last;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [INPUT_WIDTH-1:0]  r_wdata;
  logic                    r_err;
`ifdef SYSTOLIC_DMA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0]        r_tmo;
`endif

  logic                    w_acc, w_sec_end, w_pop, w_room, w_issue;
  logic [LW-1:0]           w_len_cur;
  dma_state_e              w_after, w_first;
  logic [1:0]              w_fcnt;
  logic                    w_fvalid;
  logic [RESULT_WIDTH:0]   w_fdata;

  // current section length and follow-on states
  always_comb begin
    w_len_cur = r_len_b;
    if (r_state == S_LOAD_I)
      w_len_cur = r_len_i;
    else if (r_state == S_LOAD_A)
      w_len_cur = r_len_a;
    w_after = next_load(r_state, 1'b0,
                        r_len_a != '0, r_len_b != '0);
    w_first = next_load(S_IDLE, bus.len_i != '0,
                        bus.len_a != '0, bus.len_b != '0);
  end

  assign w_acc     = bus.s_valid & r_s_ready;
  assign w_sec_end = w_acc && (r_cnt == w_len_cur - LW'(1));
  assign w_pop     = w_fvalid & bus.m_ready;
  // a word issued now lands one cycle later; reserve its slot
  assign w_room    = ({1'b0, w_fcnt} + {2'b00, r_infl})
                   < (3'd2 + {2'b00, w_pop});
  assign w_issue   = (r_state == S_DRAIN)
                   && (r_icnt != r_len_o) && w_room;

  systolic_host_dma_skid_fifo #(.W(RESULT_WIDTH + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_infl),
    .i_data  ({r_infl_last, bus.dataO}),
    .i_pop   (w_pop),
    .o_data  (w_fdata),
    .o_valid (w_fvalid),
    .o_count (w_fcnt)
  );

  // job sequencer with registered handshake and memory-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len_i     <= '0;
      r_len_a     <= '0;
      r_len_b     <= '0;
      r_len_o     <= '0;
      r_cnt       <= '0;
      r_icnt      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_s_ready   <= 1'b0;
      r_ap_start  <= 1'b0;
      r_enI       <= 1'b0;
      r_enA       <= 1'b0;
      r_enB       <= 1'b0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
`ifdef SYSTOLIC_DMA_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      r_done      <= 1'b0;
      r_ap_start  <= 1'b0;
      r_enI       <= 1'b0;
      r_enA       <= 1'b0;
      r_enB       <= 1'b0;
      r_infl      <= w_issue;
      r_infl_last <= w_issue && (r_icnt == r_len_o - LW'(1));
      if (w_issue)
        r_icnt <= r_icnt + LW'(1);
      if (w_acc) begin
        r_waddr <= r_cnt[ADDR_WIDTH-1:0];
        r_wdata <= bus.s_data;
        r_enI   <= (r_state == S_LOAD_I);
        r_enA   <= (r_state == S_LOAD_A);
        r_enB   <= (r_state == S_LOAD_B);
        r_cnt   <= w_sec_end ? '0 : r_cnt + LW'(1);
      end
      unique case (r_state)
        S_IDLE: if (bus.go) begin
          r_len_i   <= bus.len_i;
          r_len_a   <= bus.len_a;
          r_len_b   <= bus.len_b;
          r_len_o   <= bus.len_o;
          r_busy    <= 1'b1;
          r_err     <= 1'b0;
          r_state   <= w_first;
          r_s_ready <= (w_first != S_START);
        end
        S_LOAD_I, S_LOAD_A, S_LOAD_B: if (w_sec_end) begin
          r_state   <= w_after;
          r_s_ready <= (w_after != S_START);
        end
        S_START: begin
          r_ap_start <= 1'b1;
          r_state    <= S_WAIT;
`ifdef SYSTOLIC_DMA_TIMEOUT_EN
          r_tmo      <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.ap_done) begin
            if (r_len_o == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DRAIN;
            end
          end
`ifdef SYSTOLIC_DMA_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
`endif
        end
        S_DRAIN: if (w_pop && w_fdata[RESULT_WIDTH]) begin
          r_state <= S_FIN;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_icnt  <= '0;
        end
        S_FIN: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.s_ready  = r_s_ready;
  assign bus.enI      = r_enI;
  assign bus.enA      = r_enA;
  assign bus.enB      = r_enB;
  assign bus.addrI    = r_waddr;
  assign bus.addrA    = r_waddr;
  assign bus.addrB    = r_waddr;
  assign bus.dataI    = r_wdata;
  assign bus.dataA    = r_wdata;
  assign bus.dataB    = r_wdata;
  assign bus.addrO    = r_icnt[ADDR_WIDTH-1:0];
  assign bus.ap_start = r_ap_start;
  assign bus.m_valid  = w_fvalid;
  assign bus.m_data   = w_fdata[RESULT_WIDTH-1:0];
  assign bus.m_last   = w_fvalid & w_fdata[RESULT_WIDTH];
endmodule

// File: tb/tb_systolic_host_dma.sv
// Directed bench for systolic_host_dma with write/result scoreboards.
// Model controller raises ap_done ~20 cycles after ap_start.
module tb_systolic_host_dma;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_host_dma_if #(
    .INPUT_WIDTH(16), .RESULT_WIDTH(32), .ADDR_WIDTH(8)
  ) bus ();

  systolic_host_dma #(
`ifdef SYSTOLIC_DMA_TIMEOUT_EN
    .TIMEOUT_CYCLES(64),
`endif
    .INPUT_WIDTH(16), .RESULT_WIDTH(32), .ADDR_WIDTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0, n_done = 0, n_mv = 0, n_beats = 0, n_wr = 0;
  int t_start = 0, t_done = 0, t_apdone = 0, t_lastwr = 0;
  int b_start, b_done, b_mv, b_beats, b_wr;
  logic [26:0] wq[$];
  logic [32:0] rq[$];
  logic [31:0] rmem [256];
  int rdy_mode = 0;
  int rdy_i = 0;
  bit mdl_en = 1'b1;
  logic mdl_done;
  logic spur_done = 1'b0;
  int cd;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // controller model: result memory with 1-cycle read, ap_done pulse
  always @(posedge clk) bus.dataO <= rmem[bus.addrO];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cd <= 0;
      mdl_done <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (bus.ap_start && mdl_en) cd <= 19;
      else if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) mdl_done <= 1'b1;
      end
    end
  end
  assign bus.ap_done = mdl_done | spur_done;

  // output-side ready pattern
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bus.m_ready = 1'b1;
    else bus.m_ready = (rdy_i % 4 == 0) || (rdy_i % 4 == 3);
    rdy_i++;
  end

  // monitors: memory writes, result beats, pulses
  always @(negedge clk) begin
    logic [26:0] g, e;
    logic [32:0] ro, re;
    if (!rst) begin
      if (bus.ap_start) begin n_start++; t_start = cyc; end
      if (bus.done) begin n_done++; t_done = cyc; end
      if (mdl_done) t_apdone = cyc;
      if (bus.m_valid) n_mv++;
      if (bus.enI | bus.enA | bus.enB) begin
        g[26:24] = {bus.enB, bus.enA, bus.enI};
        g[23:16] = bus.enI ? bus.addrI : bus.enA ? bus.addrA : bus.addrB;
        g[15:0]  = bus.enI ? bus.dataI : bus.enA ? bus.dataA : bus.dataB;
        if (wq.size() > 0) e = wq.pop_front();
        else e = '0;
        chk("mem_write", 64'(g), 64'(e));
        n_wr++;
        t_lastwr = cyc;
      end
      if (bus.m_valid && bus.m_ready) begin
        ro = {bus.m_last, bus.m_data};
        if (rq.size() > 0) re = rq.pop_front();
        else re = 'x;
        chk("result_beat", 64'(ro), 64'(re));
        n_beats++;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk($sformatf("%s_ctl", tag),
        64'({bus.busy, bus.done, bus.err, bus.s_ready, bus.enI, bus.enA,
             bus.enB, bus.ap_start, bus.m_valid, bus.m_last}), 64'd0);
    chk($sformatf("%s_addr", tag),
        64'({bus.addrI, bus.addrA, bus.addrB, bus.addrO}), 64'd0);
    chk($sformatf("%s_data", tag),
        64'({bus.dataI, bus.dataA, bus.dataB}), 64'd0);
    chk($sformatf("%s_mdata", tag), 64'(bus.m_data), 64'd0);
  endtask

  task automatic job_start(input int li, input int la, input int lb,
                           input int lo, input int salt);
    int w;
    for (int k = 0; k < 256; k++) rmem[k] = {salt[15:0], 8'h5A, k[7:0]};
    b_start = n_start; b_done = n_done; b_mv = n_mv;
    b_beats = n_beats; b_wr = n_wr;
    w = 0;
    for (int k = 0; k < li; k++) begin
      wq.push_back({3'b001, k[7:0], w[15:0]}); w++;
    end
    for (int k = 0; k < la; k++) begin
      wq.push_back({3'b010, k[7:0], w[15:0]}); w++;
    end
    for (int k = 0; k < lb; k++) begin
      wq.push_back({3'b100, k[7:0], w[15:0]}); w++;
    end
    for (int k = 0; k < lo; k++) rq.push_back({k == lo - 1, rmem[k]});
    @(posedge clk); #1;
    bus.len_i = 9'(li); bus.len_a = 9'(la);
    bus.len_b = 9'(lb); bus.len_o = 9'(lo);
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    chk("busy_on_go", 64'(bus.busy), 64'd1);
  endtask

  task automatic feed(input int n, input int sg, input int sd);
    int w = 0;
    int guard = 0;
    logic acc;
    while (w < n && guard < 2000) begin
      bus.s_valid = 1'b1;
      bus.s_data = w[15:0];
      bus.go = (w == sg);
      spur_done = (w == sd);
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk); #1;
      if (acc) w++;
      guard++;
    end
    bus.s_valid = 1'b0;
    bus.go = 1'b0;
    spur_done = 1'b0;
    chk("feed_words", 64'(w), 64'(n));
  endtask

  task automatic wait_done(input int maxc);
    int g = 0;
    while (n_done == b_done && g < maxc) begin
      @(posedge clk); g++;
    end
    chk("done_seen", 64'(n_done != b_done), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic job_end(input string tag);
    chk($sformatf("%s_rq_empty", tag), 64'(rq.size()), 64'd0);
    chk($sformatf("%s_wq_empty", tag), 64'(wq.size()), 64'd0);
    chk($sformatf("%s_ap_starts", tag), 64'(n_start - b_start), 64'd1);
    chk($sformatf("%s_dones", tag), 64'(n_done - b_done), 64'd1);
    chk($sformatf("%s_idle", tag), 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    bus.go = 1'b0;
    bus.len_i = '0; bus.len_a = '0; bus.len_b = '0; bus.len_o = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk) rst = 1'b0;

    // basic job
    job_start(1, 4, 4, 16, 1);
    feed(9, -1, -1);
    wait_done(200);
    job_end("basic");
    chk("basic_writes", 64'(n_wr - b_wr), 64'd9);
    chk("basic_start_after_wr", 64'(t_start > t_lastwr), 64'd1);

    // backpressure 1,0,0,1
    rdy_mode = 1;
    job_start(1, 4, 4, 16, 2);
    feed(9, -1, -1);
    wait_done(400);
    job_end("bp");
    chk("bp_beats", 64'(n_beats - b_beats), 64'd16);
    rdy_mode = 0;

    // zero-length A and O
    job_start(1, 0, 2, 0, 3);
    feed(3, -1, -1);
    wait_done(200);
    job_end("zero");
    chk("zero_no_mvalid", 64'(n_mv - b_mv), 64'd0);
    chk("zero_done_lat",
        64'((t_done - t_apdone) >= 1 && (t_done - t_apdone) <= 2), 64'd1);

    // spurious go in LOAD_A, ap_done in LOAD_B
    job_start(1, 4, 4, 16, 4);
    feed(9, 2, 6);
    wait_done(200);
    job_end("spur");

    // reset after 5 drained beats, then replay drain
    job_start(1, 4, 4, 16, 5);
    feed(9, -1, -1);
    g = 0;
    while (n_beats - b_beats < 5 && g < 500) begin
      @(posedge clk); g++;
    end
    #2 rst = 1'b1;
    #1;
    chk_zero("abort");
    chk("abort_no_done", 64'(n_done - b_done), 64'd0);
    rq.delete();
    wq.delete();
    @(negedge clk) rst = 1'b0;
    job_start(0, 0, 0, 16, 5);
    wait_done(200);
    job_end("replay");
    chk("replay_beats", 64'(n_beats - b_beats), 64'd16);

    // controller never completes
    mdl_en = 1'b0;
    job_start(0, 0, 0, 4, 6);
    rq.delete();
`ifdef SYSTOLIC_DMA_TIMEOUT_EN
    wait_done(300);
    chk("tmo_err", 64'(bus.err), 64'd1);
    chk("tmo_latency", 64'(t_done - t_start), 64'd64);
    chk("tmo_no_mvalid", 64'(n_mv - b_mv), 64'd0);
    mdl_en = 1'b1;
    job_start(1, 4, 4, 16, 7);
    chk("tmo_err_cleared", 64'(bus.err), 64'd0);
    feed(9, -1, -1);
    wait_done(200);
    job_end("after_tmo");
`else
    repeat (300) @(posedge clk);
    #1;
    chk("hang_busy", 64'(bus.busy), 64'd1);
    chk("hang_no_done", 64'(n_done - b_done), 64'd0);
    chk("hang_err", 64'(bus.err), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    mdl_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
